// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with bounded burst for a single-ported data memory
module dmem_arbiter #(
  parameter int addresswidth = 32,
  parameter int width        = 32,
  parameter int MAX_BURST    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [addresswidth-1:0] addr0,
  input  logic [addresswidth-1:0] addr1,
  input  logic [width-1:0]        wdata0,
  input  logic [width-1:0]        wdata1,
  output logic                    ack0,
  output logic                    ack1,
  output logic [width-1:0]        rdata0,
  output logic [width-1:0]        rdata1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [addresswidth-1:0] mem_address,
  output logic                    mem_writeEnable,
  output logic [width-1:0]        mem_dataIn,
  input  logic [width-1:0]        mem_dataOut
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  localparam int BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

  logic [1:0]    owner;
  logic [BW-1:0] burst;
  logic          last;
  logic          g0;
  logic          g1;
  logic          burst_open;
  logic          same_owner;

  assign burst_open = (burst < BURST_MAX);
  assign same_owner = (g0 && owner == OWN0) || (g1 && owner == OWN1);

  // Grants are gated by reset so nothing reaches the memory while it is held.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if (owner == OWN0 && burst_open)      g0 = 1'b1;
        else if (owner == OWN1 && burst_open) g1 = 1'b1;
        else if (last)                        g0 = 1'b1;
        else                                  g1 = 1'b1;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
  end

  assign ack0 = g0;
  assign ack1 = g1;

  always_comb begin
    mem_address     = '0;
    mem_dataIn      = '0;
    mem_writeEnable = 1'b0;
    if (g0) begin
      mem_address     = addr0;
      mem_dataIn      = wdata0;
      mem_writeEnable = we0;
    end else if (g1) begin
      mem_address     = addr1;
      mem_dataIn      = wdata1;
      mem_writeEnable = we1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner   <= IDLE;
      burst   <= '0;
      last    <= 1'b1;
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      if (g0 || g1) begin
        owner <= g0 ? OWN0 : OWN1;
        last  <= g1;
        if (same_owner) begin
          if (burst != BURST_MAX) burst <= burst + BW'(1);
        end else begin
          burst <= BW'(1);
        end
      end else begin
        owner <= IDLE;
        burst <= '0;
      end
      rvalid0 <= g0 && !we0;
      rvalid1 <= g1 && !we1;
      if (g0 && !we0) rdata0 <= mem_dataOut;
      if (g1 && !we1) rdata1 <= mem_dataOut;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, req1, we0, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1, rvalid0, rvalid1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_dataIn, mem_dataOut;
  logic        mem_writeEnable;

  logic        b_req0, b_req1, b_we0, b_we1;
  logic [31:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
  logic        b_ack0, b_ack1, b_rvalid0, b_rvalid1;
  logic [31:0] b_rdata0, b_rdata1;
  logic [31:0] b_mem_address, b_mem_dataIn, b_mem_dataOut;
  logic        b_mem_writeEnable;

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.addresswidth(32), .width(32), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  dmem_arbiter #(.addresswidth(32), .width(32), .MAX_BURST(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
    .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
    .ack0(b_ack0), .ack1(b_ack1), .rdata0(b_rdata0), .rdata1(b_rdata1),
    .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
    .mem_address(b_mem_address), .mem_writeEnable(b_mem_writeEnable),
    .mem_dataIn(b_mem_dataIn), .mem_dataOut(b_mem_dataOut)
  );

  // Behavioural single-ported memory: combinational read, write on the clock edge.
  assign mem_dataOut   = mem[mem_address[7:0]];
  assign b_mem_dataOut = 32'hA5A5_A5A5;

  always @(posedge clk) begin
    if (mem_writeEnable) mem[mem_address[7:0]] <= mem_dataIn;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_cont;
    logic [6:0] drop_r0;
    logic [6:0] drop_exp;

    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'h1234;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0;     wdata1 = '0;
    b_req0 = 1'b0; b_req1 = 1'b0; b_we0 = 1'b1; b_we1 = 1'b1;
    b_addr0 = 32'h40; b_addr1 = 32'h44; b_wdata0 = 32'h111; b_wdata1 = 32'h222;

    // Held in reset: requests must not get through.
    step();
    settle();
    check("rst_ack0", 32'(ack0), 0);
    check("rst_we", 32'(mem_writeEnable), 0);
    check("rst_rvalid0", 32'(rvalid0), 0);
    check("rst_rdata0", rdata0, 0);
    req0 = 1'b0;
    step();
    reset = 1'b0;

    // Single-port write then read.
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    settle();
    check("wr_ack0", 32'(ack0), 1);
    check("wr_ack1", 32'(ack1), 0);
    check("wr_we", 32'(mem_writeEnable), 1);
    check("wr_addr", mem_address, 32'h10);
    check("wr_data", mem_dataIn, 32'hDEADBEEF);
    step();
    we0 = 1'b0;
    settle();
    check("rd_ack0", 32'(ack0), 1);
    check("rd_we", 32'(mem_writeEnable), 0);
    check("wr_no_rvalid", 32'(rvalid0), 0);
    step();
    req0 = 1'b0;
    settle();
    check("rd_rvalid0", 32'(rvalid0), 1);
    check("rd_rdata0", rdata0, 32'hDEADBEEF);
    check("idle_addr", mem_address, 0);
    step();
    settle();
    check("rd_rvalid0_low", 32'(rvalid0), 0);
    check("rd_rdata0_hold", rdata0, 32'hDEADBEEF);

    // Continuous contention with MAX_BURST=4.
    do_reset();
    exp_cont = 9'b011110000;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h14;
    for (int i = 0; i < 9; i++) begin
      settle();
      check($sformatf("cont_ack0_%0d", i), 32'(ack0), 32'(!exp_cont[i]));
      check($sformatf("cont_ack1_%0d", i), 32'(ack1), 32'(exp_cont[i]));
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // Owner drops early; port 1's burst count restarts at 1.
    do_reset();
    drop_r0  = 7'b1111011;
    drop_exp = 7'b0111100;
    req1 = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req0 = drop_r0[i];
      settle();
      check($sformatf("drop_ack1_%0d", i), 32'(ack1), 32'(drop_exp[i]));
      check($sformatf("drop_ack0_%0d", i), 32'(ack0), 32'(drop_r0[i] && !drop_exp[i]));
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    step();

    // MAX_BURST=1: strict alternation, then an idle cycle.
    do_reset();
    b_req0 = 1'b1; b_req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("alt_ack0_%0d", i), 32'(b_ack0), 32'(i % 2 == 0));
      check($sformatf("alt_ack1_%0d", i), 32'(b_ack1), 32'(i % 2 == 1));
      check($sformatf("alt_addr_%0d", i), b_mem_address, (i % 2 == 0) ? 32'h40 : 32'h44);
      step();
    end
    b_req0 = 1'b0; b_req1 = 1'b0;
    settle();
    check("idle_b_addr", b_mem_address, 0);
    check("idle_b_data", b_mem_dataIn, 0);
    check("idle_b_we", 32'(b_mem_writeEnable), 0);
    check("idle_b_ack", 32'({b_ack1, b_ack0}), 0);
    step();

    // Cross-port write/read ordering.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h5;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    settle();
    check("ord_ack0", 32'(ack0), 1);
    check("ord_ack1_wait", 32'(ack1), 0);
    step();
    req0 = 1'b0;
    settle();
    check("ord_ack1", 32'(ack1), 1);
    step();
    req1 = 1'b0;
    settle();
    check("ord_rvalid1", 32'(rvalid1), 1);
    check("ord_rdata1", rdata1, 32'h5);
    check("ord_rvalid0", 32'(rvalid0), 0);
    step();

    // Reset asserted while port 1 owns the memory.
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
    settle();
    check("mid_ack1_rd", 32'(ack1), 1);
    step();
    we1 = 1'b1; wdata1 = 32'h77;
    settle();
    check("mid_rvalid1", 32'(rvalid1), 1);
    check("mid_ack1_wr", 32'(ack1), 1);
    check("mid_we", 32'(mem_writeEnable), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ack1", 32'(ack1), 0);
    check("mid_rst_we", 32'(mem_writeEnable), 0);
    check("mid_rst_rvalid1", 32'(rvalid1), 0);
    check("mid_rst_rdata1", rdata1, 0);
    step();
    check("mid_rst_rvalid1_hold", 32'(rvalid1), 0);
    reset = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
    we1 = 1'b0;
    settle();
    check("post_rst_ack0", 32'(ack0), 1);
    check("post_rst_ack1", 32'(ack1), 0);
    step();
    req0 = 1'b0; req1 = 1'b0;
    settle();
    check("post_rst_rvalid0", 32'(rvalid0), 1);
    check("post_rst_dropped_wr", rdata0, 32'h5);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter that shares the single-ported `datamemory` instance between requester 0 (e.g. load/store unit) and requester 1 (e.g. DMA or debug port). It grants at most one access per cycle, drives the memory's address, write-enable and write-data pins, and registers read data back to the winning requester. Arbitration is round-robin with a bounded burst: a continuously requesting owner keeps the memory for at most `MAX_BURST` consecutive grants while the other port waits.

## Interface
- `addresswidth`, 32, width of all address buses
- `width`, 32, data word width
- `MAX_BURST`, 4, max consecutive grants to one port while the other requests (≥1)

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-high reset
- `req0` / `req1` in 1: access request, held until accepted
- `we0` / `we1` in 1: 1 = write, 0 = read
- `addr0` / `addr1` in `addresswidth`: access address
- `wdata0` / `wdata1` in `width`: write data
- `ack0` / `ack1` out 1: grant; access completes at the edge where req&ack=1
- `rdata0` / `rdata1` out `width`: registered read data
- `rvalid0` / `rvalid1` out 1: one-cycle pulse, rdata valid
- `mem_address` out `addresswidth`: to memory `address`
- `mem_writeEnable` out 1: to memory `writeEnable`
- `mem_dataIn` out `width`: to memory `dataIn`
- `mem_dataOut` in `width`: from memory `dataOut` (combinational read)

## Operation
- State: `owner` ∈ {IDLE, OWN0, OWN1}, `burst` counter (0..MAX_BURST, saturating), `last` pointer (port most recently granted).
- Grant decision (combinational, each cycle):
  - No req: no grant.
  - One req: grant it.
  - Both req, owner=OWNx and `burst`<MAX_BURST: grant x.
  - Both req, otherwise: grant the port ≠ `last`.
- Transitions at edge:
  - Grant to port x: owner←OWNx, `last`←x.
  - `burst`←`burst`+1 if x equals the previous owner, else 1.
  - No grant: owner←IDLE, `burst`←0, `last` unchanged.
- Memory drive:
  - Granted port's addr/wdata go to `mem_address`/`mem_dataIn`; `mem_writeEnable`=ack&we.
  - No grant: address, data and write-enable are all 0.
- Read: at edge of a granted read, `mem_dataOut` is captured into `rdataX`; `rvalidX`=1 next cycle only. `rdataX` holds its value until the next read by that port.
- Write: committed by the memory at the grant edge. No rvalid is produced.
- Ordering: a read granted the cycle after a write to the same address returns the new data.
- Reset (async):
  - owner=IDLE, `burst`=0, `last`=1 (port 0 wins first tie), rdata0/1=0, rvalid0/1=0.
  - While reset is high, ack0/1 and mem_writeEnable are forced 0.
  - An access in flight when reset asserts is dropped; no rvalid is produced for it.

## Timing
- ack is combinational from req and state, in the same cycle as the request. Zero-wait when uncontended.
- Read latency: rvalid/rdata 1 cycle after the accepting edge.
- Throughput: one access per cycle total; back-to-back grants to the same port are allowed.
- Worst-case wait for a requester: MAX_BURST cycles.
- Requester must hold req/we/addr/wdata stable until accepted. Dropping req before ack is legal (request withdrawn).

## Test plan
- Reset mid-burst: assert reset while ack1=1 → ack0/1, mem_writeEnable, rvalid0/1 go 0 immediately; rdata0/1=0; first tie after release grants port 0.
- Single-port write/read: req0 we0=1 addr0=0x10 wdata0=0xDEADBEEF → ack0 same cycle, mem_writeEnable=1. Next cycle read 0x10 → rvalid0=1 with rdata0=0xDEADBEEF one cycle later, then rvalid0=0.
- Continuous contention, MAX_BURST=4: req0=req1=1 from reset → ack sequence 0,0,0,0,1,1,1,1,0…; each ack is exactly one-hot.
- Owner drops early: req0 for 2 cycles, req1 asserted throughout → ack1 in cycle 3; `burst` restarts at 1.
- Write/read ordering across ports: port0 writes 0x20=0x5 while port1 waits to read 0x20 → port1 is granted afterward and rdata1=0x5.
- MAX_BURST=1 with both requesting → strict alternation 0,1,0,1; idle cycle with no req → all mem outputs 0.
